// File: rtl/external_interrupt_controller_pkg.sv
// Shared definitions for the external interrupt controller: FSM state
// encodings, source IDs and the fixed-priority selection helper.
// Build option: EIC_EDGE_DETECT_EN (edge capture) is consumed by the top.
package external_interrupt_controller_pkg;

  // Number of external interrupt sources handled by the block
  localparam int EIC_NUM_SRC = 2;

  // Request FSM state encodings
  typedef enum logic [1:0] {
    EIC_ST_IDLE = 2'd0,
    EIC_ST_REQ  = 2'd1,
    EIC_ST_HOLD = 2'd2
  } eic_state_t;

  // Source identifiers as presented on EIC_I_Id
  localparam logic EIC_ID_SRC0 = 1'b0;
  localparam logic EIC_ID_SRC1 = 1'b1;

  // Fixed priority: source 0 always wins over source 1
  function automatic logic eic_pick_id(input logic [EIC_NUM_SRC-1:0] eligible);
    return eligible[0] ? EIC_ID_SRC0 : EIC_ID_SRC1;
  endfunction

  // One-hot clear vector for the source that the core has just taken
  function automatic logic [EIC_NUM_SRC-1:0] eic_id_onehot(input logic id);
    return (id == EIC_ID_SRC1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/external_interrupt_controller_signal_synchronizer.sv
// Two-flop synchronizer for one asynchronous input bit.
// Latency: 2 clock edges from first sampling to q.
// No backpressure; the input is sampled every cycle.
module signal_synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;
  logic stable;

  // Metastability filter: first flop may go metastable, second resolves it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      stable <= 1'b0;
    end else begin
      meta   <= d;
      stable <= meta;
    end
  end

  assign q = stable;

endmodule

// File: rtl/external_interrupt_controller.sv
// External interrupt controller: synchronizes two raw interrupt lines,
// tracks pending sources and presents one request at a time to the core.
// Latency: source edge sampled at edge k -> Pending after k+2, request after k+3.
// Backpressure: a presented request is held stable until IntAck.
// Build option: EIC_EDGE_DETECT_EN selects edge capture with sticky Pending;
// undefined selects level mode (Pending follows the synchronized level).
module external_interrupt_controller
  import external_interrupt_controller_pkg::*;
(
  input  logic       Sys_Clock,
  input  logic       Sys_Reset,
  input  logic [1:0] IntSrc,
  input  logic       IntAck,
  input  logic       MaskWen,
  input  logic [1:0] MaskData,
  output logic       EIC_I_Req,
  output logic       EIC_I_Id,
  output logic [1:0] Pending,
  output logic [1:0] Mask
);

  logic [EIC_NUM_SRC-1:0] src_sync;
  logic [EIC_NUM_SRC-1:0] eligible;
  eic_state_t             state;

  // One synchronizer per interrupt source
  for (genvar gi = 0; gi < EIC_NUM_SRC; gi++) begin : g_sync
    signal_synchronizer u_sync (
      .clk (Sys_Clock),
      .rst (Sys_Reset),
      .d   (IntSrc[gi]),
      .q   (src_sync[gi])
    );
  end

  // Sources that may raise a request at the next IDLE decision
  assign eligible = Pending & Mask;

`ifdef EIC_EDGE_DETECT_EN
  logic [EIC_NUM_SRC-1:0] src_hist;
  logic [EIC_NUM_SRC-1:0] src_rise;
  logic [EIC_NUM_SRC-1:0] ack_clr;

  // History flop: previous synchronized level, used to find rising edges
  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      src_hist <= '0;
    end else begin
      src_hist <= src_sync;
    end
  end

  assign src_rise = src_sync & ~src_hist;

  // Only an ack while a request is outstanding clears the presented source
  assign ack_clr = ((state == EIC_ST_REQ) && IntAck) ? eic_id_onehot(EIC_I_Id) : '0;

  // Sticky pending: set by a rising edge, cleared by ack; set wins on a tie
  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      Pending <= '0;
    end else begin
      Pending <= (Pending & ~ack_clr) | src_rise;
    end
  end
`else
  // Level mode: pending mirrors the synchronized level; ack has no effect
  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      Pending <= '0;
    end else begin
      Pending <= src_sync;
    end
  end
`endif

  // Mask register, written by the IO path in any FSM state
  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      Mask <= '0;
    end else if (MaskWen) begin
      Mask <= MaskData;
    end
  end

  // Request FSM with registered request/ID outputs. The ID is latched on
  // entry to REQ and frozen there, because the core may stall before acking.
  // HOLD gives the core one request-free cycle to finish its pipeline flush.
  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      state     <= EIC_ST_IDLE;
      EIC_I_Req <= 1'b0;
      EIC_I_Id  <= EIC_ID_SRC0;
    end else begin
      case (state)
        EIC_ST_IDLE: begin
          if (eligible != '0) begin
            state     <= EIC_ST_REQ;
            EIC_I_Req <= 1'b1;
            EIC_I_Id  <= eic_pick_id(eligible);
          end
        end
        EIC_ST_REQ: begin
          if (IntAck) begin
            state     <= EIC_ST_HOLD;
            EIC_I_Req <= 1'b0;
          end
        end
        EIC_ST_HOLD: begin
          state     <= EIC_ST_IDLE;
          EIC_I_Req <= 1'b0;
        end
        default: begin
          state     <= EIC_ST_IDLE;
          EIC_I_Req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_external_interrupt_controller.sv
// Directed self-checking bench for external_interrupt_controller.
// Expectations hold for both capture modes; where stimulus must differ
// between edge and level mode it follows EIC_EDGE_DETECT_EN.
module tb_external_interrupt_controller;

  logic       Sys_Clock;
  logic       Sys_Reset;
  logic [1:0] IntSrc;
  logic       IntAck;
  logic       MaskWen;
  logic [1:0] MaskData;
  logic       EIC_I_Req;
  logic       EIC_I_Id;
  logic [1:0] Pending;
  logic [1:0] Mask;

  int checks = 0;
  int errors = 0;

  external_interrupt_controller dut (
    .Sys_Clock (Sys_Clock),
    .Sys_Reset (Sys_Reset),
    .IntSrc    (IntSrc),
    .IntAck    (IntAck),
    .MaskWen   (MaskWen),
    .MaskData  (MaskData),
    .EIC_I_Req (EIC_I_Req),
    .EIC_I_Id  (EIC_I_Id),
    .Pending   (Pending),
    .Mask      (Mask)
  );

  initial Sys_Clock = 1'b0;
  always #5 Sys_Clock = ~Sys_Clock;

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Sys_Clock);
      #1;
    end
  endtask

  task automatic do_reset();
    Sys_Reset = 1'b1;
    IntSrc    = 2'b00;
    IntAck    = 1'b0;
    MaskWen   = 1'b0;
    MaskData  = 2'b00;
    tick(2);
    Sys_Reset = 1'b0;
    tick(1);
  endtask

  task automatic write_mask(input logic [1:0] m);
    MaskWen  = 1'b1;
    MaskData = m;
    tick(1);
    MaskWen  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({EIC_I_Req, EIC_I_Id, Pending, Mask} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: req=%b id=%b pending=%b mask=%b, required all 0",
               EIC_I_Req, EIC_I_Id, Pending, Mask);
    end
  endtask

  task automatic test_latency();
    do_reset();
    write_mask(2'b01);
    IntSrc = 2'b01;       // first sampled at edge k
    tick(2);              // after k+1
    checks++;
    if (Pending !== 2'b00) begin
      errors++;
      $display("FAIL lat_pending_early: pending=%b required 00", Pending);
    end
    tick(1);              // after k+2
    checks++;
    if (Pending !== 2'b01) begin
      errors++;
      $display("FAIL lat_pending: pending=%b required 01", Pending);
    end
    checks++;
    if (EIC_I_Req !== 1'b0) begin
      errors++;
      $display("FAIL lat_req_early: req=%b required 0", EIC_I_Req);
    end
    tick(1);              // after k+3
    checks++;
    if (EIC_I_Req !== 1'b1 || EIC_I_Id !== 1'b0) begin
      errors++;
      $display("FAIL lat_req: req=%b id=%b required req=1 id=0", EIC_I_Req, EIC_I_Id);
    end
  endtask

  task automatic test_priority();
    do_reset();
    write_mask(2'b11);
    IntSrc = 2'b11;
    tick(4);
    checks++;
    if (EIC_I_Req !== 1'b1 || EIC_I_Id !== 1'b0) begin
      errors++;
      $display("FAIL prio_first: req=%b id=%b required req=1 id=0", EIC_I_Req, EIC_I_Id);
    end
    IntSrc = 2'b10;       // source 1 keeps its level for level mode
    tick(5);
    checks++;
    if (EIC_I_Req !== 1'b1 || EIC_I_Id !== 1'b0) begin
      errors++;
      $display("FAIL prio_hold: req=%b id=%b required req=1 id=0", EIC_I_Req, EIC_I_Id);
    end
    IntAck = 1'b1;
    tick(1);
    IntAck = 1'b0;
    checks++;
    if (EIC_I_Req !== 1'b0) begin
      errors++;
      $display("FAIL prio_hold_gap: req=%b required 0", EIC_I_Req);
    end
    checks++;
    if (Pending !== 2'b10) begin
      errors++;
      $display("FAIL prio_pending_after_ack: pending=%b required 10", Pending);
    end
    for (int i = 0; i < 4 && EIC_I_Req !== 1'b1; i++) tick(1);
    checks++;
    if (EIC_I_Req !== 1'b1 || EIC_I_Id !== 1'b1) begin
      errors++;
      $display("FAIL prio_second: req=%b id=%b required req=1 id=1", EIC_I_Req, EIC_I_Id);
    end
  endtask

  task automatic test_masked_pending();
    do_reset();
    IntSrc = 2'b10;
    tick(3);
`ifdef EIC_EDGE_DETECT_EN
    IntSrc = 2'b00;       // pulse only; edge capture keeps it pending
`endif
    tick(3);
    checks++;
    if (Pending !== 2'b10 || EIC_I_Req !== 1'b0) begin
      errors++;
      $display("FAIL masked_pending: pending=%b req=%b required pending=10 req=0", Pending, EIC_I_Req);
    end
    IntAck = 1'b1;        // stray ack outside REQ
    tick(1);
    IntAck = 1'b0;
    checks++;
    if (Pending !== 2'b10) begin
      errors++;
      $display("FAIL stray_ack: pending=%b required 10", Pending);
    end
    write_mask(2'b10);
    checks++;
    if (Mask !== 2'b10 || EIC_I_Req !== 1'b0) begin
      errors++;
      $display("FAIL unmask_write: mask=%b req=%b required mask=10 req=0", Mask, EIC_I_Req);
    end
    tick(1);
    checks++;
    if (EIC_I_Req !== 1'b1 || EIC_I_Id !== 1'b1) begin
      errors++;
      $display("FAIL unmask_req: req=%b id=%b required req=1 id=1", EIC_I_Req, EIC_I_Id);
    end
  endtask

  task automatic test_stall_and_tie();
    do_reset();
    write_mask(2'b01);
    IntSrc = 2'b01;
    tick(4);
    checks++;
    if (EIC_I_Req !== 1'b1 || EIC_I_Id !== 1'b0) begin
      errors++;
      $display("FAIL stall_start: req=%b id=%b required req=1 id=0", EIC_I_Req, EIC_I_Id);
    end
    IntSrc = 2'b00;
    write_mask(2'b00);
    checks++;
    if (Mask !== 2'b00) begin
      errors++;
      $display("FAIL stall_mask: mask=%b required 00", Mask);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if (EIC_I_Req !== 1'b1 || EIC_I_Id !== 1'b0) begin
        errors++;
        $display("FAIL stall_stable cycle %0d: req=%b id=%b required req=1 id=0", i, EIC_I_Req, EIC_I_Id);
      end
    end
    IntSrc = 2'b01;       // sampled at edge k, rise seen at k+2
    tick(2);
    IntAck = 1'b1;        // ack lands on edge k+2
    tick(1);
    IntAck = 1'b0;
    checks++;
    if (Pending[0] !== 1'b1 || EIC_I_Req !== 1'b0) begin
      errors++;
      $display("FAIL ack_tie: pending=%b req=%b required pending[0]=1 req=0", Pending, EIC_I_Req);
    end
    tick(3);
    checks++;
    if (EIC_I_Req !== 1'b0) begin
      errors++;
      $display("FAIL ack_tie_masked: req=%b required 0", EIC_I_Req);
    end
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    write_mask(2'b11);
    IntSrc = 2'b01;
    tick(4);
    checks++;
    if (EIC_I_Req !== 1'b1) begin
      errors++;
      $display("FAIL midreq_setup: req=%b required 1", EIC_I_Req);
    end
    #2;
    Sys_Reset = 1'b1;
    #1;                   // still well before the next rising edge
    checks++;
    if (EIC_I_Req !== 1'b0 || Pending !== 2'b00 || Mask !== 2'b00) begin
      errors++;
      $display("FAIL midreq_reset: req=%b pending=%b mask=%b required all 0",
               EIC_I_Req, Pending, Mask);
    end
    IntSrc = 2'b00;
    tick(1);
    Sys_Reset = 1'b0;
    tick(1);
  endtask

  initial begin
    Sys_Reset = 1'b1;
    IntSrc    = 2'b00;
    IntAck    = 1'b0;
    MaskWen   = 1'b0;
    MaskData  = 2'b00;
    test_reset();
    test_latency();
    test_priority();
    test_masked_pending();
    test_stall_and_tie();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
